// File: rtl/hist_frame_seq.sv
// Frame-level grey-level histogram sequencer: accumulates per-bin counts over the
// active VGA region, then snapshots them into a shadow bank for the overlay reader.
//
// state | meaning
// IDLE  | waiting for (0,0) with enable=1; that pixel is counted on entry
// ACCUM | counting active-region pixels into the live bins
// SNAP  | copying live[k] to shadow[k] and clearing live[k], one bin per cycle
module hist_frame_seq #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int BIN_BITS    = 4,
    parameter int COUNT_W     = 20,
    parameter int SCALE_SHIFT = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [10:0]         vga_x,
    input  logic [10:0]         vga_y,
    input  logic [7:0]          grey_in,
    input  logic [BIN_BITS-1:0] rd_bin,
    output logic [COUNT_W-1:0]  rd_count,
    output logic [7:0]          rd_height,
    output logic                busy,
    output logic                frame_done,
    output logic                hist_valid,
    output logic                sat
);

    localparam int NUM_BINS = 2 ** BIN_BITS;
    localparam int EXT_W    = (COUNT_W > 8) ? COUNT_W : 8;
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, SNAP} state_t;

    state_t              state;
    logic [COUNT_W-1:0]  live   [NUM_BINS];
    logic [COUNT_W-1:0]  shadow [NUM_BINS];
    logic [BIN_BITS-1:0] snap_idx;

    logic [BIN_BITS-1:0] pix_bin;
    logic                active;
    logic                last_pix;
    logic                frame_start;
    logic                count_en;
    logic [EXT_W-1:0]    scaled;
    logic [7:0]          height_next;
    logic                unused_grey;

    assign pix_bin     = grey_in[7 -: BIN_BITS];
    assign unused_grey = &{1'b0, grey_in};
    assign active      = (vga_x < 11'(H_ACTIVE)) && (vga_y < 11'(V_ACTIVE));
    assign last_pix    = (vga_x == 11'(H_ACTIVE - 1)) && (vga_y == 11'(V_ACTIVE - 1));
    assign frame_start = enable && (vga_x == 11'd0) && (vga_y == 11'd0);
    assign count_en    = ((state == IDLE) && frame_start) || ((state == ACCUM) && active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            snap_idx   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            hist_valid <= 1'b0;
            sat        <= 1'b0;
            for (int i = 0; i < NUM_BINS; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;

            // Count first; SNAP never counts, so this cannot collide with the clear below.
            if (count_en) begin
                if (live[pix_bin] == CNT_MAX) begin
                    sat <= 1'b1;
                end else begin
                    live[pix_bin] <= live[pix_bin] + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= ACCUM;
                        busy  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (last_pix) begin
                        state    <= SNAP;
                        snap_idx <= '0;
                    end
                end
                SNAP: begin
                    shadow[snap_idx] <= live[snap_idx];
                    live[snap_idx]   <= '0;
                    snap_idx         <= snap_idx + 1'b1;
                    if (&snap_idx) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        hist_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        scaled      = EXT_W'(shadow[rd_bin]) >> SCALE_SHIFT;
        height_next = (scaled > EXT_W'(255)) ? 8'hFF : scaled[7:0];
    end

    // Reads see the pre-write shadow value when SNAP writes the same bin this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count  <= '0;
            rd_height <= '0;
        end else begin
            rd_count  <= shadow[rd_bin];
            rd_height <= height_next;
        end
    end

endmodule

// File: tb/tb_hist_frame_seq.sv
// Directed bench for hist_frame_seq on a shrunken 10x6 raster (8x4 active, 4 bins),
// plus a narrow-counter instance sharing the same stimulus to exercise saturation.
module tb_hist_frame_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [10:0] vga_x;
    logic [10:0] vga_y;
    logic [7:0]  grey_in;
    logic [1:0]  rd_bin;

    logic [19:0] rd_count;
    logic [7:0]  rd_height;
    logic        busy, frame_done, hist_valid, sat;

    logic [3:0]  s_rd_count;
    logic [7:0]  s_rd_height;
    logic        s_busy, s_frame_done, s_hist_valid, s_sat;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    logic        busy_seen;
    logic [19:0] snap_obs [3];

    always #5 clk = ~clk;

    hist_frame_seq #(.H_ACTIVE(8), .V_ACTIVE(4), .BIN_BITS(2), .COUNT_W(20), .SCALE_SHIFT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vga_x(vga_x), .vga_y(vga_y),
        .grey_in(grey_in), .rd_bin(rd_bin), .rd_count(rd_count), .rd_height(rd_height),
        .busy(busy), .frame_done(frame_done), .hist_valid(hist_valid), .sat(sat)
    );

    hist_frame_seq #(.H_ACTIVE(8), .V_ACTIVE(4), .BIN_BITS(2), .COUNT_W(4), .SCALE_SHIFT(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vga_x(vga_x), .vga_y(vga_y),
        .grey_in(grey_in), .rd_bin(rd_bin), .rd_count(s_rd_count), .rd_height(s_rd_height),
        .busy(s_busy), .frame_done(s_frame_done), .hist_valid(s_hist_valid), .sat(s_sat)
    );

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] grey_of(input int mode, input int x, input int y);
        bit act;
        act = (x < 8) && (y < 4);
        case (mode)
            0: return 8'h40;
            1: return act ? ((x % 2 == 1) ? 8'hC0 : 8'h00) : 8'hFF;
            2: return 8'h80;
            3: return (act && x < 4) ? 8'h80 : 8'h00;
            4: return 8'hC0;
            5: return (act && (y * 8 + x) < 20) ? 8'h40 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    // One 10x6 raster; returns early (before driving) at linear index stop_idx.
    task automatic scan(input int mode, input int drop_row, input int stop_idx);
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 10; x++) begin
                @(negedge clk);
                if (y * 10 + x == stop_idx) return;
                if (y == 0 && x == 1) busy_seen = busy;
                if (y == 4 && x < 3) snap_obs[x] = rd_count;
                if (y == drop_row && x == 0) enable = 1'b0;
                vga_x   = 11'(x);
                vga_y   = 11'(y);
                grey_in = grey_of(mode, x, y);
            end
        end
    endtask

    task automatic rdchk(input string tag, input logic [1:0] bin, input int exp_cnt, input int exp_h);
        @(negedge clk);
        rd_bin = bin;
        @(negedge clk);
        chk($sformatf("%s_count_bin%0d", tag, bin), 32'(rd_count), exp_cnt);
        chk($sformatf("%s_height_bin%0d", tag, bin), 32'(rd_height), exp_h);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; vga_x = 11'd9; vga_y = 11'd5; grey_in = 8'h00; rd_bin = 2'd0;
        busy_seen = 1'bx;
        repeat (2) @(negedge clk);
        chk("rst_rd_count", 32'(rd_count), 0);
        chk("rst_rd_height", 32'(rd_height), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_hist_valid", 32'(hist_valid), 0);
        chk("rst_sat", 32'(sat), 0);
        rst_n = 1'b1;

        // Frame 1: every pixel 0x40 -> bin1 gets all 32 active pixels
        enable = 1'b1;
        scan(0, -1, -1);
        repeat (2) @(negedge clk);
        chk("f1_busy_accum", 32'(busy_seen), 1);
        chk("f1_frame_done_pulses", fd_cnt, 1);
        chk("f1_hist_valid", 32'(hist_valid), 1);
        chk("f1_busy_idle", 32'(busy), 0);
        rdchk("f1", 2'd1, 32, 8);
        rdchk("f1", 2'd0, 0, 0);
        rdchk("f1", 2'd2, 0, 0);
        rdchk("f1", 2'd3, 0, 0);

        // Frame 2: active alternates 0x00/0xC0, blanking 0xFF must be ignored
        scan(1, -1, -1);
        repeat (2) @(negedge clk);
        chk("f2_frame_done_pulses", fd_cnt, 2);
        rdchk("f2", 2'd0, 16, 4);
        rdchk("f2", 2'd3, 16, 4);
        rdchk("f2", 2'd1, 0, 0);
        rdchk("f2", 2'd2, 0, 0);

        // Frame 3: all 0x80 -> live bins were cleared by the previous SNAP
        scan(2, -1, -1);
        rdchk("f3", 2'd2, 32, 8);
        rdchk("f3", 2'd0, 0, 0);
        rdchk("f3", 2'd3, 0, 0);

        // Frame 4: rd_bin held at 2 across SNAP; old value until after k=2
        rd_bin = 2'd2;
        scan(3, -1, -1);
        chk("f4_snap_read_k1", 32'(snap_obs[0]), 32);
        chk("f4_snap_read_k2", 32'(snap_obs[1]), 32);
        chk("f4_snap_read_after_k2", 32'(snap_obs[2]), 16);
        rdchk("f4", 2'd0, 16, 4);
        chk("f4_frame_done_pulses", fd_cnt, 4);

        // Frame 5: enable low at (0,0) -> no frame, shadow untouched
        enable = 1'b0;
        scan(0, -1, -1);
        repeat (2) @(negedge clk);
        chk("f5_busy_disabled", 32'(busy_seen), 0);
        chk("f5_frame_done_pulses", fd_cnt, 4);
        rdchk("f5", 2'd2, 16, 4);

        // Frame 6: enable dropped on row 1, frame still completes
        enable = 1'b1;
        scan(4, 1, -1);
        repeat (2) @(negedge clk);
        chk("f6_busy_accum", 32'(busy_seen), 1);
        chk("f6_frame_done_pulses", fd_cnt, 5);
        rdchk("f6", 2'd2, 0, 0);
        rdchk("f6", 2'd3, 32, 8);

        // Frame 7: reset asserted while SNAP is at k=1
        enable = 1'b1;
        scan(0, -1, 39);
        rst_n = 1'b0;
        #1;
        chk("snaprst_rd_count", 32'(rd_count), 0);
        chk("snaprst_rd_height", 32'(rd_height), 0);
        chk("snaprst_busy", 32'(busy), 0);
        chk("snaprst_frame_done", 32'(frame_done), 0);
        chk("snaprst_hist_valid", 32'(hist_valid), 0);
        chk("snaprst_sat_narrow", 32'(s_sat), 0);
        @(negedge clk);
        vga_x = 11'd9; vga_y = 11'd5; grey_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("snaprst_no_frame_done", fd_cnt, 5);
        chk("snaprst_busy_after", 32'(busy), 0);
        rdchk("snaprst", 2'd3, 0, 0);

        // Frame 8: 20 pixels in bin1 -> 4-bit counter saturates at 15
        scan(5, -1, -1);
        repeat (2) @(negedge clk);
        rdchk("f8", 2'd1, 20, 5);
        chk("f8_narrow_count_bin1", 32'(s_rd_count), 15);
        chk("f8_narrow_height_bin1", 32'(s_rd_height), 3);
        rdchk("f8", 2'd0, 12, 3);
        chk("f8_narrow_count_bin0", 32'(s_rd_count), 12);
        chk("f8_narrow_sat", 32'(s_sat), 1);
        chk("f8_sat", 32'(sat), 0);
        chk("f8_hist_valid", 32'(hist_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hist_frame_seq.md
Name: hist_frame_seq

Overview:
- Frame-level sequencer for the on-screen grey-level histogram.
- Arms at the top of a VGA frame and accumulates per-bin pixel counts over the active region only.
- At end of frame, snapshots all bins into a shadow bank one bin per cycle, clearing each live counter as it goes.
- The overlay renderer reads the stable shadow bank through a registered read port while the next frame accumulates.

Parameters:
- H_ACTIVE, 640, active pixels per line; pixel counted only when vga_x < H_ACTIVE.
- V_ACTIVE, 480, active lines per frame; pixel counted only when vga_y < V_ACTIVE.
- BIN_BITS, 4, log2 of bin count; NUM_BINS = 2**BIN_BITS; bin index = grey_in[7:8-BIN_BITS].
- COUNT_W, 20, width of each live and shadow counter.
- SCALE_SHIFT, 10, right shift applied to shadow count for rd_height.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  accumulation enable; sampled only in IDLE at frame start.
- vga_x  in  11  current scan column.
- vga_y  in  11  current scan row.
- grey_in  in  8  grey value of pixel at (vga_x, vga_y).
- rd_bin  in  BIN_BITS  shadow bank read address.
- rd_count  out  COUNT_W  shadow[rd_bin], registered.
- rd_height  out  8  min(shadow[rd_bin] >> SCALE_SHIFT, 255), registered.
- busy  out  1  high in ACCUM and SNAP.
- frame_done  out  1  one-cycle pulse when a snapshot completes.
- hist_valid  out  1  sticky; high once the first snapshot has completed.
- sat  out  1  sticky; high if any live counter saturated since reset.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All live counters, shadow bank, snap index, rd_count, rd_height, busy, frame_done, hist_valid and sat go to 0.
  - Reset asserted mid-ACCUM or mid-SNAP discards all partial data.
- States: IDLE, ACCUM, SNAP.
- IDLE:
  - Moves to ACCUM when enable=1 and vga_x==0 and vga_y==0.
  - The (0,0) pixel of that cycle is counted.
  - With enable=0 it stays in IDLE and counts nothing.
- ACCUM:
  - Each cycle with vga_x<H_ACTIVE and vga_y<V_ACTIVE increments live[bin(grey_in)] by 1.
  - Saturates at 2**COUNT_W-1 and sets sat.
  - Pixels outside the active region are ignored.
  - Pixel (H_ACTIVE-1, V_ACTIVE-1) is counted, and state moves to SNAP in the same cycle.
  - enable is not re-checked; a started frame always completes.
- SNAP:
  - Runs exactly NUM_BINS cycles; snap index k counts 0..NUM_BINS-1.
  - In cycle k: shadow[k] <= live[k]; live[k] <= 0.
  - Pixels arriving during SNAP are not counted.
  - After cycle NUM_BINS-1: frame_done=1 for one cycle, hist_valid<=1, then IDLE.
  - The next frame starts only at the following (0,0) with enable=1.
- Read port:
  - rd_count and rd_height update one cycle after rd_bin.
  - If rd_bin == k while SNAP writes shadow[k], the read returns the pre-write (old) value.
- busy is a registered decode of state: 1 in ACCUM/SNAP, 0 in IDLE.
- Arithmetic: all unsigned; rd_height clamps at 255 before truncation.

Test Plan:
- Params H_ACTIVE=8, V_ACTIVE=4, BIN_BITS=2, SCALE_SHIFT=2; enable=1; one full 10x6 scan with every active pixel grey=0x40 -> after 4 SNAP cycles frame_done pulses once; shadow[1]=32, others 0; hist_valid=1; rd_height for bin1 = 8.
- Same params; active pixels alternate grey 0x00/0xC0, blanking pixels grey=0xFF -> shadow[0]=16, shadow[3]=16, shadow[2]=0 (blanking ignored).
- Second frame all grey 0x80 -> shadow[2]=32, shadow[0]=0, shadow[3]=0, showing live counters were cleared during SNAP.
- enable=0 at frame start -> stays IDLE, busy=0, no frame_done; enable dropped mid-ACCUM -> frame still completes and snaps.
- Hold rd_bin=2 across SNAP -> rd_count shows old shadow[2] until the cycle after k=2, then the new value.
- Assert rst_n=0 in SNAP at k=1 -> all outputs 0 immediately, state IDLE; COUNT_W=4 with 20 same-bin pixels -> live count holds at 15 and sat=1.
